// File: rtl/mem_arbiter.sv
// Arbitrates one ram256x8 port between the CPU MEM stage and a debug/loader port.
// Define MEM_ARB_STARVE_GUARD_EN to force-grant debug after STARVE_MAX blocked cycles.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        R,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic        cpu_size,
  input  logic [7:0]  cpu_addr,
  input  logic [31:0] cpu_di,
  output logic [31:0] cpu_do,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_rw,
  input  logic        dbg_size,
  input  logic [7:0]  dbg_addr,
  input  logic [31:0] dbg_di,
  output logic        dbg_ack,
  output logic [31:0] dbg_do,
  output logic        ram_E,
  output logic        ram_RW,
  output logic        ram_Size,
  output logic [7:0]  ram_A,
  output logic [31:0] ram_DI,
  input  logic [31:0] ram_DO
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DBG_ACC = 2'd1,
    DBG_ACK = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        dbg_rw_q, dbg_rw_d;
  logic        dbg_size_q, dbg_size_d;
  logic [7:0]  dbg_addr_q, dbg_addr_d;
  logic [31:0] dbg_di_q, dbg_di_d;
  logic [31:0] dbg_do_q, dbg_do_d;
  logic        force_grant;
  logic        accept;

  // Counter is 3 bits wide, so only 1..7 is meaningful.
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_starve_max_out_of_range
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbg_req || accept) begin
      starve_cnt_d = '0;
    end else if (state_q == IDLE && cpu_req &&
                 starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  assign force_grant = (starve_cnt_q == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (R) starve_cnt_q <= '0;
    else   starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_grant = 1'b0;
`endif

  assign accept = (state_q == IDLE) && dbg_req &&
                  (!cpu_req || force_grant);

  always_comb begin
    state_d    = state_q;
    dbg_rw_d   = dbg_rw_q;
    dbg_size_d = dbg_size_q;
    dbg_addr_d = dbg_addr_q;
    dbg_di_d   = dbg_di_q;
    dbg_do_d   = dbg_do_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = DBG_ACC;
          dbg_rw_d   = dbg_rw;
          dbg_size_d = dbg_size;
          dbg_addr_d = dbg_addr;
          dbg_di_d   = dbg_di;
        end
      end
      DBG_ACC: begin
        state_d = DBG_ACK;
        if (!dbg_rw_q) begin
          dbg_do_d = dbg_size_q ? ram_DO : {24'h0, ram_DO[7:0]};
        end
      end
      DBG_ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= IDLE;
      dbg_rw_q   <= 1'b0;
      dbg_size_q <= 1'b0;
      dbg_addr_q <= '0;
      dbg_di_q   <= '0;
      dbg_do_q   <= '0;
    end else begin
      state_q    <= state_d;
      dbg_rw_q   <= dbg_rw_d;
      dbg_size_q <= dbg_size_d;
      dbg_addr_q <= dbg_addr_d;
      dbg_di_q   <= dbg_di_d;
      dbg_do_q   <= dbg_do_d;
    end
  end

  // Debug owns the RAM only in DBG_ACC; otherwise the CPU does.
  always_comb begin
    ram_E    = 1'b0;
    ram_RW   = 1'b0;
    ram_Size = 1'b0;
    ram_A    = '0;
    ram_DI   = '0;
    if (state_q == DBG_ACC) begin
      ram_E    = 1'b1;
      ram_RW   = dbg_rw_q;
      ram_Size = dbg_size_q;
      ram_A    = dbg_addr_q;
      ram_DI   = dbg_di_q;
    end else if (cpu_req) begin
      ram_E    = 1'b1;
      ram_RW   = cpu_rw;
      ram_Size = cpu_size;
      ram_A    = cpu_addr;
      ram_DI   = cpu_di;
    end
  end

  assign cpu_stall = (state_q == DBG_ACC) && cpu_req;
  assign dbg_ack   = (state_q == DBG_ACK);
  assign cpu_do    = ram_DO;
  assign dbg_do    = dbg_do_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning: consecutive blocked cycles before the debug port is force-granted (range 1..7).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 R  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  pipeline MEM-stage access request (MEM_Enable_signal).
REQ-005 cpu_rw, cpu_size  input  1 each  CPU write(1)/read(0); word(1)/byte(0).
REQ-006 cpu_addr  input  8  CPU byte address.
REQ-007 cpu_di  input  32  CPU write data.
REQ-008 cpu_do  output  32  CPU read data, combinational copy of ram_DO.
REQ-009 cpu_stall  output  1  CPU access not performed this cycle; pipeline holds.
REQ-010 dbg_req, dbg_rw, dbg_size  input  1 each  debug/loader request, write(1)/read(0), word(1)/byte(0).
REQ-011 dbg_addr  input  8; dbg_di  input  32  debug address and write data.
REQ-012 dbg_ack  output  1  one-cycle completion pulse.
REQ-013 dbg_do  output  32  registered debug read data.
REQ-014 ram_E, ram_RW, ram_Size  output  1 each  drive ram256x8 E, RW, Size.
REQ-015 ram_A  output  8; ram_DI  output  32; ram_DO  input  32  RAM address, write data, combinational read data.

Function
REQ-016 FSM states SHALL be IDLE, DBG_ACC, DBG_ACK.
REQ-017 IDLE: cpu_req=1 -> RAM driven from cpu_* (ram_E=1), cpu_stall=0; cpu_req=0 and dbg_req=0 -> ram_E=0, ram_A/ram_DI=0.
REQ-018 IDLE -> DBG_ACC when dbg_req=1 and (cpu_req=0 or force grant per REQ-026); dbg_rw/size/addr/di latched into internal registers on that edge.
REQ-019 DBG_ACC: RAM driven from latched debug fields, ram_E=1; cpu_stall=cpu_req; next state DBG_ACK unconditionally.
REQ-020 DBG_ACC edge: read -> dbg_do <= ram_DO (byte read: dbg_do={24'b0,ram_DO[7:0]}); write -> dbg_do holds.
REQ-021 DBG_ACK: dbg_ack=1 for exactly this cycle; CPU served as in IDLE; new dbg_req not accepted; next state IDLE.
REQ-022 Debug latency: acceptance edge to dbg_ack = 2 cycles; minimum 3 cycles between successive dbg acceptances.
REQ-023 dbg_req SHALL be held by the requester until dbg_ack; dropping it in DBG_ACC/DBG_ACK does not abort the transaction.
REQ-024 cpu_stall SHALL be 0 in IDLE and DBG_ACK; CPU is never served in DBG_ACC.
REQ-025 Simultaneous cpu_req and dbg_req in IDLE without force grant: CPU served, debug waits.

Reset
REQ-026 (with macro, see REQ-030) force grant: IDLE, dbg_req=1, starve_cnt==STARVE_MAX -> accept debug; CPU still served that IDLE cycle.
REQ-027 R=1 at an edge: state<=IDLE, dbg_do<=0, latched fields<=0, starve_cnt<=0; takes priority over all transitions, including mid-DBG_ACC (transaction discarded, no dbg_ack).
REQ-028 Outputs while R=1 after the edge: cpu_stall=0, dbg_ack=0, ram_E follows IDLE rules.

Configuration
REQ-029 Macro MEM_ARB_STARVE_GUARD_EN selects the starvation guard.
REQ-030 Defined: 3-bit starve_cnt increments (saturating at STARVE_MAX) each IDLE cycle with dbg_req=1 and cpu_req=1; clears on debug acceptance or dbg_req=0; REQ-026 active.
REQ-031 Undefined: no counter; strict CPU priority; debug accepted only when cpu_req=0.

Verification
REQ-032 Reset: R=1 during DBG_ACC -> next cycle state IDLE, dbg_ack=0, dbg_do=0.
REQ-033 CPU only: cpu_req=1, rw=0, size=1, addr=52 with RAM[52..55]=0x01020304 -> cpu_do=0x01020304, cpu_stall=0, same cycle.
REQ-034 Debug byte write addr=58, di=0x000000AB, CPU idle -> ram_RW=1, ram_A=58 in DBG_ACC; dbg_ack 2 cycles after acceptance; RAM[58]=0xAB.
REQ-035 Debug byte read addr=56 (RAM=0x7F) with cpu_req rising in DBG_ACC -> cpu_stall=1 one cycle, dbg_do=0x0000007F with dbg_ack.
REQ-036 Guard on, STARVE_MAX=4, cpu_req and dbg_req held high -> debug accepted after 4 blocked cycles, cpu_stall=1 exactly one cycle; guard off -> never accepted, dbg_ack=0 throughout.
